// File: rtl/draw_pkg.sv
// Shared opcodes, FSM state encoding and command-word field helpers for the span engine.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package draw_pkg;

    localparam logic [2:0]  OP_HSPAN  = 3'b000;
    localparam logic [2:0]  OP_RECT   = 3'b001;
    localparam logic [15:0] CMD_CLEAR = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_W1   = 3'd2,
        ST_W2   = 3'd3,
        ST_DRAW = 3'd4,
        ST_FILL = 3'd5
    } state_t;

    function automatic logic [2:0] word_op(input logic [15:0] w);
        return w[15:13];
    endfunction

    function automatic logic [7:0] word_x0(input logic [15:0] w);
        return w[15:8];
    endfunction

    function automatic logic [7:0] word_x1(input logic [15:0] w);
        return w[7:0];
    endfunction

    // Extract a parameter-dependent field (colour, y) from a command word.
    function automatic logic [15:0] word_field(input logic [15:0] w, input int lsb, input int width);
        logic [15:0] mask;
        mask = 16'((32'd1 << width) - 32'd1);
        return (w >> lsb) & mask;
    endfunction

    function automatic logic [7:0] clamp_x(input logic [7:0] x, input logic [7:0] x_max);
        return (x > x_max) ? x_max : x;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for command words.
// Latency: a word pushed into an empty FIFO is poppable on the next cycle.
// Backpressure: push is refused while full (full sampled before any same-cycle pop); pop ignored when empty.
//  Ports: clk, reset (sync, high); push/din write side; pop/dout read side; full, empty, count status.
module cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/draw_span_engine.sv
// Decodes queued span/rect/clear commands and rasterises them into framebuffer pixel writes.
// Latency: first fb_we one cycle after the command's last word is popped; then 1 pixel/clk.
// Backpressure: fb_we/fb_addr/fb_data hold while fb_ready=0; command FIFO full drops pushes (sticky overflow).
//  Ports: clk, reset (sync, high); we/dataIn/full/overflow command side; err pulse, busy status;
//         fb_ready/fb_we/fb_addr/fb_data framebuffer write port.
module draw_span_engine
    import draw_pkg::*;
#(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int COLOR_W    = 3,
    parameter int FIFO_DEPTH = 16,
    // Derived widths; leave at their defaults.
    parameter int Y_W        = $clog2(V_RES),
    parameter int ADDR_W     = $clog2(H_RES * V_RES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [15:0]        dataIn,
    output logic               full,
    output logic               overflow,
    output logic               err,
    output logic               busy,
    input  logic               fb_ready,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data
);

    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]       X_MAX     = 8'(H_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    // Command FIFO
    logic [15:0]      word;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             pop;

    cmd_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (we),
        .din   (dataIn),
        .pop   (pop),
        .dout  (word),
        .full  (full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head-word decode
    logic [2:0]         w_op;
    logic [COLOR_W-1:0] w_col;
    logic [Y_W-1:0]     w_y;

    assign w_op  = word_op(word);
    assign w_col = COLOR_W'(word_field(word, Y_W, COLOR_W));
    assign w_y   = Y_W'(word_field(word, 0, Y_W));

    // State and registers
    state_t             state;
    state_t             next_state;
    logic               rect_r;
    logic [COLOR_W-1:0] col_r;
    logic [Y_W-1:0]     y0_r;
    logic [7:0]         x0_r;
    logic [7:0]         x1_r;
    logic [7:0]         x_cur;
    logic [7:0]         x_lo;
    logic [7:0]         x_hi;
    logic [Y_W-1:0]     y_cur;
    logic [Y_W-1:0]     y_hi;
    logic [ADDR_W-1:0]  row_base;

    // Setup path: normalise the command once, when its last word is popped.
    // HSPAN finishes in W1 (x from the head word); RECT finishes in W2 (x from registers, y1 from head).
    logic [7:0]        sx0, sx1, cx0, cx1, set_xlo, set_xhi;
    logic [Y_W-1:0]    sy1, set_ylo, set_yhi;
    logic              y_bad;
    logic [ADDR_W-1:0] set_row;

    always_comb begin
        sx0     = (state == ST_W1) ? word_x0(word) : x0_r;
        sx1     = (state == ST_W1) ? word_x1(word) : x1_r;
        sy1     = (state == ST_W2) ? w_y : y0_r;
        cx0     = clamp_x(sx0, X_MAX);
        cx1     = clamp_x(sx1, X_MAX);
        set_xlo = (cx0 > cx1) ? cx1 : cx0;
        set_xhi = (cx0 > cx1) ? cx0 : cx1;
        set_ylo = (y0_r > sy1) ? sy1 : y0_r;
        set_yhi = (y0_r > sy1) ? y0_r : sy1;
        // Extra bit so V_RES == 2**Y_W still compares correctly.
        y_bad   = ({1'b0, set_yhi} >= (Y_W + 1)'(V_RES));
        // Single per-command multiply; the pixel loop itself only adds.
        set_row = ADDR_W'(set_ylo) * ROW_STEP;
    end

    // FSM
    logic step;
    logic last_pix;
    logic fill_last;
    logic load_draw;
    logic load_fill;
    logic err_set;

    assign step      = fb_we & fb_ready;
    assign last_pix  = (x_cur == x_hi) && (y_cur == y_hi);
    assign fill_last = (fb_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load_draw  = 1'b0;
        load_fill  = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) next_state = ST_W0;
            end
            ST_W0: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (word == CMD_CLEAR) begin
                        load_fill  = 1'b1;
                        next_state = ST_FILL;
                    end else if (w_op == OP_HSPAN || w_op == OP_RECT) begin
                        next_state = ST_W1;
                    end else begin
                        err_set    = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_W1: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (rect_r) begin
                        next_state = ST_W2;
                    end else if (y_bad) begin
                        err_set    = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        load_draw  = 1'b1;
                        next_state = ST_DRAW;
                    end
                end
            end
            ST_W2: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (y_bad) begin
                        err_set    = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        load_draw  = 1'b1;
                        next_state = ST_DRAW;
                    end
                end
            end
            ST_DRAW: begin
                if (step && last_pix) next_state = ST_IDLE;
            end
            ST_FILL: begin
                if (step && fill_last) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE) || (fifo_count != '0);

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            err      <= 1'b0;
            rect_r   <= 1'b0;
            col_r    <= '0;
            y0_r     <= '0;
            x0_r     <= '0;
            x1_r     <= '0;
            x_cur    <= '0;
            x_lo     <= '0;
            x_hi     <= '0;
            y_cur    <= '0;
            y_hi     <= '0;
            row_base <= '0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
        end else begin
            overflow <= overflow | (we & full);
            err      <= err_set;

            if (state == ST_W0 && pop) begin
                rect_r <= (w_op == OP_RECT);
                col_r  <= w_col;
                y0_r   <= w_y;
            end
            if (state == ST_W1 && pop) begin
                x0_r <= word_x0(word);
                x1_r <= word_x1(word);
            end

            if (load_draw) begin
                fb_we    <= 1'b1;
                fb_addr  <= set_row + ADDR_W'(set_xlo);
                fb_data  <= col_r;
                row_base <= set_row;
                x_cur    <= set_xlo;
                x_lo     <= set_xlo;
                x_hi     <= set_xhi;
                y_cur    <= set_ylo;
                y_hi     <= set_yhi;
            end else if (load_fill) begin
                fb_we   <= 1'b1;
                fb_addr <= '0;
                fb_data <= '0;
            end else if (step) begin
                if (state == ST_FILL) begin
                    if (fill_last) fb_we <= 1'b0;
                    else           fb_addr <= fb_addr + ADDR_W'(1);
                end else if (x_cur != x_hi) begin
                    x_cur   <= x_cur + 8'd1;
                    fb_addr <= fb_addr + ADDR_W'(1);
                end else if (y_cur != y_hi) begin
                    y_cur    <= y_cur + Y_W'(1);
                    x_cur    <= x_lo;
                    row_base <= row_base + ROW_STEP;
                    fb_addr  <= row_base + ROW_STEP + ADDR_W'(x_lo);
                end else begin
                    fb_we <= 1'b0;
                end
            end
        end
    end

endmodule
